// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types and constants for the keypad scan core
package keypad_pkg;

  // Debounce states; HELD and RELEASE both report a key as held.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONFIRM = 2'd1,
    HELD    = 2'd2,
    RELEASE = 2'd3
  } db_state_t;

  // Raw scan result: bit 4 is the valid flag, bits 3:0 the key code.
  localparam logic [4:0] NONE = 5'b0_0000;

  localparam logic [1:0] REG_STATUS = 2'd0;
  localparam logic [1:0] REG_DATA   = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  // Index of the lowest set bit; only meaningful when v is non-zero.
  function automatic logic [1:0] low_idx(input logic [3:0] v);
    if (v[0])      return 2'd0;
    else if (v[1]) return 2'd1;
    else if (v[2]) return 2'd2;
    else           return 2'd3;
  endfunction

endpackage

// File: rtl/keypad_fifo.sv
// rtl/keypad_fifo.sv - 4-entry x 4-bit key code FIFO
module keypad_fifo
  import keypad_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [3:0] wdata,
  output logic [3:0] head,
  output logic       full,
  output logic       empty,
  output logic [2:0] count,
  output logic       drop
);

  logic [3:0] mem [4];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic       do_push;
  logic       do_pop;

  assign full    = (count == 3'd4);
  assign empty   = (count == 3'd0);
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign drop    = push && full && !pop;
  assign head    = mem[rd_ptr];

  // Storage is not reset; empty gates what the host sees.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 2'd1;
      if (do_pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/keypad_scan_core.sv
// rtl/keypad_scan_core.sv - 4x4 keypad scanner with debounce and code FIFO
module keypad_scan_core
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 100_000,
  parameter int DB_SCANS = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        read,
  input  logic        write,
  input  logic [4:0]  addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic [3:0]  col,
  input  logic [3:0]  row
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DB_SCANS + 1);

  logic [3:0]    row_m, row_s;
  logic [DW-1:0] div_cnt;
  logic [1:0]    col_idx;
  logic [1:0]    acc_cnt;
  logic [3:0]    acc_code;
  logic          col_end, scan_end;
  logic [3:0]    hit;
  logic [2:0]    col_hits, tot;
  logic [3:0]    tot_code;
  logic [4:0]    raw;
  db_state_t     state, state_n;
  logic [3:0]    cand, cand_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          push, pop, clr, drop, overflow, held;
  logic [3:0]    head;
  logic          full, empty;
  logic [2:0]    count;
  logic          unused_ok;

  assign unused_ok = ^{wr_data, addr[4:2], full};

  // Two-stage synchronizer for the asynchronous row lines.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_m <= 4'hF;
      row_s <= 4'hF;
    end else begin
      row_m <= row;
      row_s <= row_m;
    end
  end

  assign col_end  = (div_cnt == DW'(SCAN_DIV - 1));
  assign scan_end = col_end && (col_idx == 2'd3);
  assign col      = ~(4'b0001 << col_idx);

  // Column period divider and column index.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
      col_idx <= 2'd0;
    end else if (col_end) begin
      div_cnt <= '0;
      col_idx <= col_idx + 2'd1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Combine this column's sample with the running scan tally; the count
  // saturates at 2 since only "exactly one key" matters.
  assign hit      = ~row_s;
  assign col_hits = {2'b0, hit[0]} + {2'b0, hit[1]} + {2'b0, hit[2]} + {2'b0, hit[3]};
  assign tot      = {1'b0, acc_cnt} + col_hits;
  assign tot_code = (col_hits != 3'd0) ? {low_idx(hit), col_idx} : acc_code;
  assign raw      = (tot == 3'd1) ? {1'b1, tot_code} : NONE;

  // Per-scan accumulator, cleared at every end of scan.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_cnt  <= 2'd0;
      acc_code <= 4'd0;
    end else if (scan_end) begin
      acc_cnt  <= 2'd0;
      acc_code <= 4'd0;
    end else if (col_end) begin
      acc_cnt  <= (tot >= 3'd2) ? 2'd2 : tot[1:0];
      acc_code <= tot_code;
    end
  end

  // Debounce state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cand  <= 4'd0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cand  <= cand_n;
      cnt   <= cnt_n;
    end
  end

  // Debounce next state; push fires on the edge ending the last matching scan.
  always_comb begin
    state_n = state;
    cand_n  = cand;
    cnt_n   = cnt;
    push    = 1'b0;
    if (scan_end) begin
      case (state)
        IDLE: begin
          if (raw[4]) begin
            state_n = CONFIRM;
            cand_n  = raw[3:0];
            cnt_n   = CW'(1);
          end
        end
        CONFIRM: begin
          if (raw == {1'b1, cand}) begin
            if (cnt == CW'(DB_SCANS - 1)) begin
              push    = 1'b1;
              state_n = HELD;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt + 1'b1;
            end
          end else begin
            state_n = IDLE;
            cnt_n   = '0;
          end
        end
        HELD: begin
          if (!raw[4]) begin
            state_n = RELEASE;
            cnt_n   = CW'(1);
          end
        end
        RELEASE: begin
          if (!raw[4]) begin
            if (cnt == CW'(DB_SCANS - 1)) begin
              state_n = IDLE;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt + 1'b1;
            end
          end else begin
            state_n = HELD;
            cnt_n   = '0;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign held = (state == HELD) || (state == RELEASE);
  assign pop  = cs && read && (addr[1:0] == REG_DATA);
  assign clr  = cs && write && (addr[1:0] == REG_CTRL);

  keypad_fifo u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (cand),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count),
    .drop  (drop)
  );

  // Sticky overflow; a drop in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    overflow <= 1'b0;
    else if (drop) overflow <= 1'b1;
    else if (clr)  overflow <= 1'b0;
  end

  // Register read mux.
  always_comb begin
    rd_data = 32'd0;
    case (addr[1:0])
      REG_STATUS: rd_data = {26'd0, overflow, held, 1'b0, count};
      REG_DATA:   rd_data = empty ? 32'd0 : {27'd0, 1'b1, head};
      default:    rd_data = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_keypad_scan_core.sv
// tb/tb_keypad_scan_core.sv - directed bench for keypad_scan_core
module tb_keypad_scan_core;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs, read, write;
  logic [4:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [15:0] keys;
  int          total  = 0;
  int          passed = 0;

  always #5 clk = ~clk;

  keypad_scan_core #(.SCAN_DIV(4), .DB_SCANS(3)) dut (
    .clk     (clk),
    .reset   (reset),
    .cs      (cs),
    .read    (read),
    .write   (write),
    .addr    (addr),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .col     (col),
    .row     (row)
  );

  // Keypad matrix: a pressed key at code r*4+c pulls row r low while column c is driven.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      row[r] = ~|(keys[r*4 +: 4] & ~col);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    else passed++;
  endtask

  task automatic bus_rd(input logic [4:0] a, output logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; read = 1'b1; addr = a;
    #1 d = rd_data;
    @(negedge clk);
    cs = 1'b0; read = 1'b0; addr = 5'd0;
  endtask

  task automatic bus_wr(input logic [4:0] a);
    @(negedge clk);
    cs = 1'b1; write = 1'b1; addr = a; wr_data = 32'hFFFF_FFFF;
    @(negedge clk);
    cs = 1'b0; write = 1'b0; addr = 5'd0; wr_data = 32'd0;
  endtask

  task automatic scans(input int n);
    repeat (n * 16) @(posedge clk);
  endtask

  task automatic press(input int code);
    keys = 16'd0;
    keys[code] = 1'b1;
  endtask

  logic [31:0] d;
  logic [3:0]  exp_col [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
  int          codes [5]   = '{0, 3, 9, 12, 15};

  initial begin
    reset = 1'b0; cs = 1'b0; read = 1'b0; write = 1'b0;
    addr = 5'd0; wr_data = 32'd0; keys = 16'd0;
    #1;
    chk("reset_col", {28'd0, col}, 32'h0000_000E);
    chk("reset_status", rd_data, 32'h0);
    addr = 5'd1; #1;
    chk("reset_data", rd_data, 32'h0);
    addr = 5'd0;
    @(negedge clk); reset = 1'b1;
    chk("col_0", {28'd0, col}, 32'hE);
    for (int i = 0; i < 4; i++) begin
      repeat (4) @(negedge clk);
      chk($sformatf("col_step%0d", i + 1), {28'd0, col}, {28'd0, exp_col[i]});
    end
    bus_rd(5'd0, d); chk("idle_status", d, 32'h00);
    bus_rd(5'd1, d); chk("idle_data", d, 32'h00);

    // Single clean press of row 2 / column 1.
    press(9); scans(10);
    bus_rd(5'd0, d); chk("held_status", d, 32'h11);
    keys = 16'd0; scans(5);
    bus_rd(5'd0, d); chk("released_status", d, 32'h01);
    bus_rd(5'd1, d); chk("key9_data", d, 32'h19);
    bus_rd(5'd0, d); chk("after_pop_status", d, 32'h00);
    bus_rd(5'd1, d); chk("empty_pop_data", d, 32'h00);
    bus_rd(5'd0, d); chk("empty_pop_status", d, 32'h00);
    bus_rd(5'd2, d); chk("addr2_read", d, 32'h00);
    bus_rd(5'd3, d); chk("addr3_read", d, 32'h00);

    // Bounce shorter than the debounce window.
    press(9); repeat (32) @(posedge clk);
    keys = 16'd0; scans(5);
    bus_rd(5'd0, d); chk("short_status", d, 32'h00);

    // Two keys together never register.
    keys = 16'd0; keys[5] = 1'b1; keys[6] = 1'b1; scans(6);
    bus_rd(5'd0, d); chk("two_keys_status", d, 32'h00);
    keys = 16'd0; scans(5);
    // Key 5 debounced, then key 6 joins: only key 5 is queued.
    press(5); scans(6);
    bus_rd(5'd0, d); chk("key5_held", d, 32'h11);
    keys[6] = 1'b1; scans(6);
    bus_rd(5'd0, d); chk("key5_6_status", d, 32'h01);
    keys = 16'd0; scans(5);
    bus_rd(5'd0, d); chk("key5_only_one", d, 32'h01);
    bus_rd(5'd1, d); chk("key5_data", d, 32'h15);
    bus_rd(5'd0, d); chk("key5_drained", d, 32'h00);

    // Five presses into a four-entry FIFO.
    for (int i = 0; i < 5; i++) begin
      press(codes[i]); scans(5);
      keys = 16'd0; scans(5);
    end
    bus_rd(5'd0, d); chk("overflow_status", d, 32'h24);
    for (int i = 0; i < 4; i++) begin
      bus_rd(5'd1, d);
      chk($sformatf("fifo_rd%0d", i), d, 32'h10 | codes[i]);
    end
    bus_rd(5'd1, d); chk("fifo_rd_empty", d, 32'h00);
    bus_rd(5'd0, d); chk("ovf_sticky", d, 32'h20);
    bus_wr(5'd2);
    bus_rd(5'd0, d); chk("ovf_cleared", d, 32'h00);

    // Reset mid-debounce with one entry queued.
    press(10); scans(5);
    keys = 16'd0; scans(5);
    bus_rd(5'd0, d); chk("queued_status", d, 32'h01);
    press(6); scans(2);
    bus_rd(5'd0, d); chk("confirm_status", d, 32'h01);
    @(posedge clk); #3 reset = 1'b0;
    addr = 5'd0; #1;
    chk("async_col", {28'd0, col}, 32'hE);
    chk("async_status", rd_data, 32'h00);
    addr = 5'd1; #1;
    chk("async_data", rd_data, 32'h00);
    addr = 5'd0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    scans(2);
    bus_rd(5'd0, d); chk("post_reset_partial", d, 32'h00);
    scans(3);
    bus_rd(5'd0, d); chk("post_reset_held", d, 32'h11);
    keys = 16'd0; scans(5);
    bus_rd(5'd1, d); chk("post_reset_data", d, 32'h16);
    bus_rd(5'd0, d); chk("post_reset_final", d, 32'h00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
